axis_deskew: RTL and testbench

//  Realigns the staircase-skewed lanes leaving the systolic array into one AXI-Stream word per row.

---
 rtl/axis_deskew.sv | 148 ++++++++++++++
 tb/tb_axis_deskew.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_deskew.sv
// Removes the lane-k, k-cycle staircase skew and queues aligned words in a DEPTH-entry FIFO (R cycles lane 0 -> m_valid).
// Upstream is throttled by a lane-0 credit (s_ready); the output is plain valid/ready straight from the FIFO head.
module axis_deskew #(
  parameter int R     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic           c,
  input  logic           rst,
  input  logic [R-1:0]   s_valid,
  input  logic [R*W-1:0] s_data,
  input  logic           s_last,
  output logic           s_ready,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [R*W-1:0] m_data,
  output logic           m_last,
  output logic           err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(R + 1);
  localparam int SW = $clog2(DEPTH + R + 1);

  logic           accept;
  logic [R-1:0]   lane_vld;
  logic [R-1:0]   al_vld;
  logic [R*W-1:0] al_dat;
  logic           al_last;
  logic           wr_en;
  logic           rd_en;
  logic           mismatch;
  logic           drop;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IW-1:0]  inflight_q, inflight_d;
  logic           err_q, err_d;
  logic [R*W-1:0] mem_q [DEPTH];
  logic           last_mem_q [DEPTH];

  // Credit depends on state only, so upstream can decide within the cycle.
  assign s_ready = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
  assign accept  = s_valid[0] & s_ready;
  assign drop    = s_valid[0] & ~s_ready;

  always_comb begin
    lane_vld    = s_valid;
    lane_vld[0] = accept;
  end

  for (genvar k = 0; k < R; k++) begin : g_lane
    localparam int D = R - 1 - k;
    if (D == 0) begin : g_pass
      assign al_vld[k]        = lane_vld[k];
      assign al_dat[k*W +: W] = s_data[k*W +: W];
    end else begin : g_dly
      logic [D-1:0]        vld_q;
      logic [D-1:0][W-1:0] dat_q;
      always_ff @(posedge c) begin
        if (rst) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q[0] <= lane_vld[k];
          dat_q[0] <= s_data[k*W +: W];
          for (int j = 1; j < D; j++) begin
            vld_q[j] <= vld_q[j-1];
            dat_q[j] <= dat_q[j-1];
          end
        end
      end
      assign al_vld[k]        = vld_q[D-1];
      assign al_dat[k*W +: W] = dat_q[D-1];
    end
  end

  if (R == 1) begin : g_last_pass
    assign al_last = s_last;
  end else begin : g_last_dly
    logic [R-2:0] last_q;
    always_ff @(posedge c) begin
      if (rst) begin
        last_q <= '0;
      end else begin
        last_q[0] <= s_last;
        for (int j = 1; j < R - 1; j++) begin
          last_q[j] <= last_q[j-1];
        end
      end
    end
    assign al_last = last_q[R-2];
  end

  assign wr_en    = al_vld[0];
  assign rd_en    = m_valid & m_ready;
  assign mismatch = |(al_vld ^ {R{al_vld[0]}});

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (!wr_en && rd_en) count_d = count_q - CW'(1);
    if (accept && !wr_en)      inflight_d = inflight_q + IW'(1);
    else if (!accept && wr_en) inflight_d = inflight_q - IW'(1);
    err_d = err_q | mismatch | drop;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Storage is not reset; m_valid gates whatever it holds.
  always_ff @(posedge c) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q]      <= al_dat;
      last_mem_q[wr_ptr_q] <= al_last;
    end
  end

  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign m_last  = m_valid & last_mem_q[rd_ptr_q];
  assign err     = err_q;

endmodule

// File: tb/tb_axis_deskew.sv
// Scoreboard bench for axis_deskew: a skewing driver pushes expected words, a negedge monitor pops and compares.
module tb_axis_deskew;
  localparam int R     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   s_valid;
  logic [R*W-1:0] s_data;
  logic           s_last;
  logic           s_ready;
  logic           m_valid;
  logic           m_ready;
  logic [R*W-1:0] m_data;
  logic           m_last;
  logic           err;

  axis_deskew #(.R(R), .W(W), .DEPTH(DEPTH)) dut (
    .c(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  logic [R*W:0] exp_q[$];
  int           beat_cyc[$];
  bit           sch_v [R][64];
  logic [W-1:0] sch_d [R][64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard pop, hold-while-stalled and no-write-when-full.
  bit           stall_p = 1'b0;
  logic [R*W-1:0] stall_d;
  logic         stall_l;
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p && m_valid) begin
        chk("hold_data", 64'(m_data), 64'(stall_d));
        chk("hold_last", 64'(m_last), 64'(stall_l));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_data), 64'hDEAD);
        end else begin
          logic [R*W:0] e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_data), 64'(e[R*W-1:0]));
          chk("beat_last", 64'(m_last), 64'(e[R*W]));
        end
        beat_cyc.push_back(cyc);
      end
      if (dut.wr_en) chk("write_when_full", 64'(int'(dut.count_q) >= DEPTH), 64'd0);
      stall_p = m_valid && !m_ready;
      stall_d = m_data;
      stall_l = m_last;
    end
  end

  // One cycle of stimulus; lanes k>0 of an accepted word are scheduled k cycles later.
  task automatic drive(input bit offer, input logic [R*W-1:0] word, input bit last,
                       input int late, input bit rst_in, output bit acc);
    int slot;
    slot = cyc % 64;
    acc = 1'b0;
    rst = rst_in;
    s_valid = '0;
    s_data  = '0;
    s_last  = 1'b0;
    for (int k = 1; k < R; k++) begin
      if (sch_v[k][slot]) begin
        s_valid[k] = 1'b1;
        s_data[k*W +: W] = sch_d[k][slot];
        sch_v[k][slot] = 1'b0;
      end
    end
    if (offer && s_ready && !rst_in) begin
      logic [R*W-1:0] e;
      acc = 1'b1;
      n_acc++;
      s_valid[0] = 1'b1;
      s_data[0 +: W] = word[0 +: W];
      s_last = last;
      e = word;
      for (int k = 1; k < R; k++) begin
        int d;
        d = k + ((k == late) ? 1 : 0);
        sch_v[k][(slot + d) % 64] = 1'b1;
        sch_d[k][(slot + d) % 64] = word[k*W +: W];
      end
      if (late > 0) e[late*W +: W] = '0;
      exp_q.push_back({last, e});
    end
    @(posedge clk);
    #1;
    if (rst_in) begin
      exp_q.delete();
      beat_cyc.delete();
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, -1, 1'b0, a);
  endtask

  task automatic do_reset(input string nm);
    bit a;
    m_ready = 1'b0;
    drive(1'b0, '0, 1'b0, -1, 1'b1, a);
    chk({nm, "_rst_m_valid"}, 64'(m_valid), 64'd0);
    chk({nm, "_rst_m_last"},  64'(m_last),  64'd0);
    chk({nm, "_rst_err"},     64'(err),     64'd0);
    chk({nm, "_rst_s_ready"}, 64'(s_ready), 64'd1);
    n_acc = 0;
  endtask

  function automatic logic [R*W-1:0] mkw(input int w, input int step);
    logic [R*W-1:0] v;
    for (int k = 0; k < R; k++) v[k*W +: W] = W'(w * step + k);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int t0;
    int w;
    rst = 1'b1; s_valid = '0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    for (int k = 0; k < R; k++) for (int s = 0; s < 64; s++) sch_v[k][s] = 1'b0;
    @(posedge clk); #1;

    // 1: single word
    do_reset("t1");
    m_ready = 1'b1;
    t0 = cyc;
    drive(1'b1, 32'h13121110, 1'b1, -1, 1'b0, a);
    idle(8);
    chk("t1_beats", 64'(beat_cyc.size()), 64'd1);
    if (beat_cyc.size() > 0) chk("t1_cycle", 64'(beat_cyc[0] - t0), 64'd4);
    chk("t1_err", 64'(err), 64'd0);

    // 2: back-to-back stream
    do_reset("t2");
    m_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, mkw(i, 16), (i == 15), -1, 1'b0, a);
      chk("t2_accept", 64'(a), 64'd1);
    end
    idle(8);
    chk("t2_beats", 64'(beat_cyc.size()), 64'd16);
    for (int i = 0; i < 16 && i < beat_cyc.size(); i++)
      chk("t2_beat_cycle", 64'(beat_cyc[i] - t0), 64'(4 + i));
    chk("t2_err", 64'(err), 64'd0);

    // 3: backpressure
    do_reset("t3");
    w = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, mkw(w, 16), 1'b0, -1, 1'b0, a);
      if (a) w++;
    end
    chk("t3_admitted", 64'(n_acc), 64'd8);
    chk("t3_s_ready_low", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    idle(1);
    chk("t3_s_ready_rise", 64'(s_ready), 64'd1);
    idle(12);
    chk("t3_beats", 64'(beat_cyc.size()), 64'd8);
    chk("t3_err", 64'(err), 64'd0);

    // 4: lane 2 of word 0 one cycle late
    do_reset("t4");
    m_ready = 1'b1;
    drive(1'b1, 32'hA3A2A1A0, 1'b0, 2, 1'b0, a);
    idle(3);
    chk("t4_err_set", 64'(err), 64'd1);
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b1, mkw(i + 1, 16), 1'b0, -1, 1'b0, a);
    idle(8);
    chk("t4_err_held", 64'(err), 64'd1);
    chk("t4_beats", 64'(beat_cyc.size()), 64'd4);

    // 5: reset with 3 words stored and 2 in flight
    do_reset("t5pre");
    for (int i = 0; i < 5; i++) drive(1'b1, mkw(i, 16), 1'b0, -1, 1'b0, a);
    idle(1);
    chk("t5_count", 64'(dut.count_q), 64'd3);
    chk("t5_inflight", 64'(dut.inflight_q), 64'd2);
    chk("t5_m_valid", 64'(m_valid), 64'd1);
    do_reset("t5");
    m_ready = 1'b1;
    idle(8);
    chk("t5_no_output", 64'(beat_cyc.size()), 64'd0);

    // 6: wrap with m_ready toggling
    do_reset("t6");
    w = 0;
    for (int i = 0; i < 200 && w < 20; i++) begin
      m_ready = (i % 2 == 0);
      drive(1'b1, mkw(w, 4), (w % 5 == 4), -1, 1'b0, a);
      if (a) w++;
    end
    chk("t6_sent", 64'(w), 64'd20);
    for (int i = 0; i < 100 && beat_cyc.size() < 20; i++) begin
      m_ready = (i % 2 == 0);
      idle(1);
    end
    m_ready = 1'b1;
    idle(2);
    chk("t6_beats", 64'(beat_cyc.size()), 64'd20);
    chk("t6_leftover", 64'(exp_q.size()), 64'd0);
    chk("t6_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
